// File: rtl/wb_dual_write_sequencer.sv
// ---------------------------------------------------------------------------
// wb_dual_write_sequencer
// MEM/WB pipeline register plus write-back sequencer for a pipeline whose
// instructions may have two destinations. The register file has one write
// port, so a dual-destination instruction spends two cycles in WB: first
// write_reg, then write_reg2. wb_stall holds all upstream stages during the
// first of those two cycles.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   freeze              global freeze; holds every register, blocks rf writes
//   *_MEM               MEM-stage instruction fields and candidate values
//   *_WB                registered WB fields, consumed by the forwarding unit
//   rf_we/waddr/wdata   register-file write port
//   wb_stall            hold IF..MEM (and this stage) for one cycle
// ---------------------------------------------------------------------------
module wb_dual_write_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  reg_write_en_MEM,
   input  logic                  dual_MEM,
   input  logic                  mem_read_MEM,
   input  logic [REG_AW-1:0]     write_reg_MEM,
   input  logic [REG_AW-1:0]     write_reg2_MEM,
   input  logic [DATA_WIDTH-1:0] alu_result_MEM,
   input  logic [DATA_WIDTH-1:0] mem_data_MEM,
   input  logic [DATA_WIDTH-1:0] result2_MEM,
   output logic                  reg_write_en_WB,
   output logic [REG_AW-1:0]     write_reg_WB,
   output logic [REG_AW-1:0]     write_reg2_WB,
   output logic [DATA_WIDTH-1:0] wb_value_WB,
   output logic [DATA_WIDTH-1:0] wb_value2_WB,
   output logic                  rf_we,
   output logic [REG_AW-1:0]     rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  wb_stall
);

   typedef enum logic {PH_FIRST = 1'b0, PH_SECOND = 1'b1} phase_e;

   phase_e                  phase_q, phase_d;
   logic                    reg_write_en_q, reg_write_en_d;
   logic                    dual_q, dual_d;
   logic [REG_AW-1:0]       write_reg_q, write_reg_d;
   logic [REG_AW-1:0]       write_reg2_q, write_reg2_d;
   logic [DATA_WIDTH-1:0]   wb_value_q, wb_value_d;
   logic [DATA_WIDTH-1:0]   wb_value2_q, wb_value2_d;
   logic                    capture;

   always_comb begin
      // The first phase of an enabled dual instruction needs one more cycle.
      wb_stall = reg_write_en_q & dual_q & (phase_q == PH_FIRST);
      capture  = ~freeze & ~wb_stall;

      reg_write_en_d = reg_write_en_q;
      dual_d         = dual_q;
      write_reg_d    = write_reg_q;
      write_reg2_d   = write_reg2_q;
      wb_value_d     = wb_value_q;
      wb_value2_d    = wb_value2_q;
      if (capture) begin
         reg_write_en_d = reg_write_en_MEM;
         dual_d         = dual_MEM;
         write_reg_d    = write_reg_MEM;
         write_reg2_d   = write_reg2_MEM;
         wb_value_d     = mem_read_MEM ? mem_data_MEM : alu_result_MEM;
         wb_value2_d    = result2_MEM;
      end

      // Phase only advances on unfrozen cycles, so a pending write survives a
      // freeze and is issued exactly once afterwards.
      phase_d = phase_q;
      if (!freeze) phase_d = wb_stall ? PH_SECOND : PH_FIRST;

      rf_we    = reg_write_en_q & ~freeze;
      rf_waddr = (phase_q == PH_SECOND) ? write_reg2_q : write_reg_q;
      rf_wdata = (phase_q == PH_SECOND) ? wb_value2_q  : wb_value_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q        <= PH_FIRST;
         reg_write_en_q <= 1'b0;
         dual_q         <= 1'b0;
         write_reg_q    <= '0;
         write_reg2_q   <= '0;
         wb_value_q     <= '0;
         wb_value2_q    <= '0;
      end else begin
         phase_q        <= phase_d;
         reg_write_en_q <= reg_write_en_d;
         dual_q         <= dual_d;
         write_reg_q    <= write_reg_d;
         write_reg2_q   <= write_reg2_d;
         wb_value_q     <= wb_value_d;
         wb_value2_q    <= wb_value2_d;
      end
   end

   // Forwarding outputs come straight from the WB registers; they hold across
   // both phases of a dual write.
   assign reg_write_en_WB = reg_write_en_q;
   assign write_reg_WB    = write_reg_q;
   assign write_reg2_WB   = write_reg2_q;
   assign wb_value_WB     = wb_value_q;
   assign wb_value2_WB    = wb_value2_q;

endmodule
